vn_debias_packer: RTL and testbench



---
 rtl/vn_debias_packer.sv | 161 ++++++++++++++++
 tb/tb_vn_debias_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vn_debias_packer.sv
// vn_debias_packer
// Von Neumann debiasing of a raw entropy bit stream, followed by LSB-first
// packing into WIDTH-bit words on a valid/ready output. A sticky overflow flag
// and a saturating discarded-pair counter feed health monitoring.

module vn_debias_packer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int                BC_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0]   LAST_POS = BC_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } pair_state_t;

    pair_state_t      state_r, state_nxt_s;
    logic             b0_r, b0_nxt_s;
    logic             emit_s, drop_s;
    logic [WIDTH-1:0] shift_r, shift_nxt_s, shift_set_s;
    logic [BC_W-1:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic             word_done_s;
    logic [WIDTH-1:0] data_r, data_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic             overflow_r, overflow_nxt_s;
    logic [CNT_W-1:0] drop_cnt_r, drop_cnt_nxt_s;

    // Pair FSM next state: disabling flushes any half pair without counting it.
    always_comb begin
        state_nxt_s = state_r;
        b0_nxt_s    = b0_r;
        emit_s      = 1'b0;
        drop_s      = 1'b0;
        if (!enable) begin
            state_nxt_s = FIRST;
        end else if (bit_valid) begin
            case (state_r)
                FIRST: begin
                    state_nxt_s = SECOND;
                    b0_nxt_s    = bit_in;
                end
                SECOND: begin
                    state_nxt_s = FIRST;
                    if (bit_in != b0_r) begin
                        emit_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = FIRST;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Packer: the debiased bit equals the held first bit; the last bit completes the word.
    always_comb begin
        shift_set_s            = shift_r;
        shift_set_s[bit_cnt_r] = b0_r;
        word_done_s            = emit_s && (bit_cnt_r == LAST_POS);
        shift_nxt_s            = shift_r;
        bit_cnt_nxt_s          = bit_cnt_r;
        if (word_done_s) begin
            shift_nxt_s   = {WIDTH{1'b0}};
            bit_cnt_nxt_s = {BC_W{1'b0}};
        end else if (emit_s) begin
            shift_nxt_s   = shift_set_s;
            bit_cnt_nxt_s = bit_cnt_r + BC_W'(1);
        end else begin
            shift_nxt_s   = shift_r;
            bit_cnt_nxt_s = bit_cnt_r;
        end
    end

    // Output register: load when free or being consumed, otherwise drop and flag overflow.
    always_comb begin
        data_nxt_s     = data_r;
        valid_nxt_s    = valid_r;
        overflow_nxt_s = overflow_r;
        if (word_done_s && (!valid_r || out_ready)) begin
            data_nxt_s  = shift_set_s;
            valid_nxt_s = 1'b1;
        end else if (word_done_s) begin
            overflow_nxt_s = 1'b1;
        end else if (valid_r && out_ready) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // Discarded-pair counter saturates at all-ones instead of wrapping.
    always_comb begin
        drop_cnt_nxt_s = drop_cnt_r;
        if (drop_s && (drop_cnt_r != CNT_MAX)) begin
            drop_cnt_nxt_s = drop_cnt_r + CNT_W'(1);
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Pair FSM and held first bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FIRST;
            b0_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            b0_r    <= b0_nxt_s;
        end
    end

    // Partial word shift register and its bit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {BC_W{1'b0}};
        end else begin
            shift_r   <= shift_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
        end
    end

    // Output word, valid flag and health status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r     <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            data_r     <= data_nxt_s;
            valid_r    <= valid_nxt_s;
            overflow_r <= overflow_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_vn_debias_packer.sv
// Bench for vn_debias_packer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.

module tb_vn_debias_packer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, enable, bit_valid, bit_in, out_ready;
    logic [7:0]   out_data;
    logic         out_valid, overflow;
    logic [15:0]  drop_cnt;
    logic [3:0]   s_out_data;
    logic         s_out_valid, s_overflow;
    logic [3:0]   s_drop_cnt;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    bit         m_have_b0, m_b0, m_valid, m_ovf;
    logic [7:0] m_data;
    int         m_drop;
    bit         m_bits[$];

    vn_debias_packer #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bit_valid(bit_valid), .bit_in(bit_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    // narrow-counter instance used to exercise drop_cnt saturation
    vn_debias_packer #(.WIDTH(4), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .enable(enable), .bit_valid(bit_valid), .bit_in(bit_in),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .overflow(s_overflow), .drop_cnt(s_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] w;
        if (rst) begin
            m_have_b0 = 0; m_b0 = 0; m_valid = 0; m_ovf = 0;
            m_data = 8'h00; m_drop = 0; m_bits.delete();
        end else begin
            if (!enable) begin
                m_have_b0 = 0;
            end else if (bit_valid) begin
                if (!m_have_b0) begin
                    m_b0 = bit_in; m_have_b0 = 1;
                end else begin
                    m_have_b0 = 0;
                    if (bit_in != m_b0) m_bits.push_back(m_b0);
                    else if (m_drop < 65535) m_drop++;
                end
            end
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) w[i] = m_bits[i];
                m_bits.delete();
                if (!m_valid || out_ready) begin
                    m_data = w; m_valid = 1;
                end else begin
                    m_ovf = 1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) chk("out_data", {24'd0, out_data}, {24'd0, m_data});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_cnt", {16'd0, drop_cnt}, m_drop);
        chk("drop_cnt_sat4", {28'd0, s_drop_cnt}, (m_drop > 15) ? 32'd15 : m_drop);
    endtask

    task automatic cycle(input bit en, input bit bv, input bit bi, input bit rdy, input bit r);
        enable = en; bit_valid = bv; bit_in = bi; out_ready = rdy; rst = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pair(input bit a, input bit b, input bit rdy);
        cycle(1'b1, 1'b1, a, rdy, 1'b0);
        cycle(1'b1, 1'b1, b, rdy, 1'b0);
    endtask

    initial begin
        enable = 0; bit_valid = 0; bit_in = 0; out_ready = 0; rst = 1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_data", {24'd0, out_data}, 32'h0);
        chk("reset_valid", {31'd0, out_valid}, 32'h0);
        chk("reset_ovf", {31'd0, overflow}, 32'h0);
        chk("reset_drop", {16'd0, drop_cnt}, 32'h0);

        // alternating pairs -> 0x55, valid for one cycle
        for (int i = 0; i < 4; i++) begin
            pair(1'b1, 1'b0, 1'b1);
            pair(1'b0, 1'b1, 1'b1);
        end
        chk("t1_valid", {31'd0, out_valid}, 32'h1);
        chk("t1_data", {24'd0, out_data}, 32'h55);
        chk("t1_ovf", {31'd0, overflow}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_valid_clr", {31'd0, out_valid}, 32'h0);

        // equal pairs are discarded and counted
        for (int i = 0; i < 3; i++) begin
            pair(1'b0, 1'b0, 1'b1);
            pair(1'b1, 1'b1, 1'b1);
        end
        chk("t2_drop", {16'd0, drop_cnt}, 32'd6);
        chk("t2_valid", {31'd0, out_valid}, 32'h0);

        // output blocked: first 0xFF held, second dropped
        for (int i = 0; i < 16; i++) pair(1'b1, 1'b0, 1'b0);
        chk("t3_data", {24'd0, out_data}, 32'hFF);
        chk("t3_valid", {31'd0, out_valid}, 32'h1);
        chk("t3_ovf", {31'd0, overflow}, 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_consumed", {31'd0, out_valid}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_once", {31'd0, out_valid}, 32'h0);
        chk("t3_ovf_sticky", {31'd0, overflow}, 32'h1);

        // enable gap drops held b0, partial word of three ones survives -> 0x07
        for (int i = 0; i < 3; i++) pair(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pair(1'b0, 1'b0, 1'b1);
        chk("t4_drop", {16'd0, drop_cnt}, 32'd7);
        chk("t4_novalid", {31'd0, out_valid}, 32'h0);
        for (int i = 0; i < 5; i++) pair(1'b0, 1'b1, 1'b1);
        chk("t4_valid", {31'd0, out_valid}, 32'h1);
        chk("t4_data", {24'd0, out_data}, 32'h07);

        // simultaneous consume and load
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) pair(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pair(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pair(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_held", {24'd0, out_data}, 32'hFF);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_data", {24'd0, out_data}, 32'h0F);
        chk("t5_valid", {31'd0, out_valid}, 32'h1);
        chk("t5_ovf", {31'd0, overflow}, 32'h0);

        // reset mid-word with a held b0
        for (int i = 0; i < 5; i++) pair(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_data", {24'd0, out_data}, 32'h0);
        chk("t6_valid", {31'd0, out_valid}, 32'h0);
        chk("t6_drop", {16'd0, drop_cnt}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pair(1'b0, 1'b1, 1'b1);
            pair(1'b1, 1'b0, 1'b1);
        end
        chk("t6_word", {24'd0, out_data}, 32'hAA);
        chk("t6_wvalid", {31'd0, out_valid}, 32'h1);

        // saturation on the 4-bit counter
        for (int i = 0; i < 20; i++) pair(1'b1, 1'b1, 1'b1);
        chk("sat4", {28'd0, s_drop_cnt}, 32'd15);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 499) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
